// File: rtl/da_fir_core.sv
// da_fir_core: bit-serial distributed-arithmetic FIR filter with loadable partial-sum LUTs.
// LUT reads are registered, so each bit's partial sum is accumulated one cycle after it is addressed.
module da_fir_core #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 64,
  parameter int LUT_K  = 8,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 21,
  parameter int SAT_EN = 1,
  localparam int NLUT  = TAPS / LUT_K,
  localparam int LW    = COEF_W + $clog2(LUT_K),
  localparam int AW    = $clog2(NLUT) + LUT_K,
  localparam int SW    = COEF_W + $clog2(TAPS),
  localparam int ACC_W = SW + DATA_W,
  localparam int BW    = $clog2(DATA_W)
) (
  input  logic              clk_fast,
  input  logic              resetn,
  input  logic [DATA_W-1:0] din,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              CLOAD,
  input  logic [AW-1:0]     CADDR,
  input  logic [LW-1:0]     CIN,
  output logic [OUT_W-1:0]  dout,
  output logic              valid_out
);
  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
  localparam longint MAXL = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(MAXL);
  localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(-MAXL - 64'sd1);
  localparam logic signed [ACC_W:0] RND = SHIFT > 0 ? (ACC_W + 1)'(64'sd1 <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  state_t state_q, state_d;
  logic [DATA_W-1:0] taps_q [TAPS];
  logic [DATA_W-1:0] taps_d [TAPS];
  logic [LW-1:0] lut_q [2**AW];
  logic [LW-1:0] rd_q [NLUT];
  logic [LW-1:0] rd_d [NLUT];
  logic [AW-1:0] ra [NLUT];
  logic [BW-1:0] bit_q, bit_d, pb_q, pb_d;
  logic pv_q, pv_d, op_q, op_d, valid_out_q, valid_out_d, accept;
  logic signed [ACC_W-1:0] acc_q, acc_d, term;
  logic signed [SW-1:0] sum;
  logic signed [ACC_W:0] rnd_acc, r;
  logic [OUT_W-1:0] dout_q, dout_d, sat_out;
  assign ready_in = state_q == IDLE && !CLOAD;
  assign dout = dout_q;
  assign valid_out = valid_out_q;
  always_comb begin
    accept = valid_in && ready_in;
    sum = '0;
    for (int t = 0; t < NLUT; t++) begin
      ra[t] = AW'(t * (2**LUT_K));
      for (int i = 0; i < LUT_K; i++) ra[t][i] = taps_q[t*LUT_K+i][bit_q];
      rd_d[t] = lut_q[ra[t]];
      sum = sum + SW'($signed(rd_q[t]));
    end
    term = ACC_W'(sum) <<< pb_q;
    acc_d = accept ? '0 : !pv_q ? acc_q : pb_q == BW'(DATA_W - 1) ? acc_q - term : acc_q + term;
    taps_d[0] = accept ? din : taps_q[0];
    for (int k = 1; k < TAPS; k++) taps_d[k] = accept ? taps_q[k-1] : taps_q[k];
    state_d = state_q == IDLE ? (accept ? COMPUTE : IDLE) :
              state_q == COMPUTE ? (bit_q == BW'(DATA_W - 1) ? OUTPUT : COMPUTE) : IDLE;
    bit_d = state_q == COMPUTE ? bit_q + 1'b1 : '0;
    pb_d = bit_q;
    pv_d = state_q == COMPUTE;
    op_d = state_q == OUTPUT;
    rnd_acc = {acc_q[ACC_W-1], acc_q} + RND;
    r = rnd_acc >>> SHIFT;
    sat_out = SAT_EN != 0 && r > MAXV ? MAXV[OUT_W-1:0] :
              SAT_EN != 0 && r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
    dout_d = op_q ? sat_out : dout_q;
    valid_out_d = op_q;
  end
  always_ff @(posedge clk_fast) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
      bit_q <= '0;
      pb_q <= '0;
      pv_q <= 1'b0;
      op_q <= 1'b0;
      acc_q <= '0;
      dout_q <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taps_q <= taps_d;
      bit_q <= bit_d;
      pb_q <= pb_d;
      pv_q <= pv_d;
      op_q <= op_d;
      acc_q <= acc_d;
      dout_q <= dout_d;
      valid_out_q <= valid_out_d;
    end
  end
  // LUT storage survives reset; writes only land while idle
  always_ff @(posedge clk_fast) begin
    if (CLOAD && state_q == IDLE) lut_q[CADDR] <= CIN;
    rd_q <= rd_d;
  end
endmodule

// File: tb/tb_da_fir_core.sv
// tb_da_fir_core: random and directed stimulus on three parameterisations checked against a direct-form FIR model.
module tb_da_fir_core;
  logic clk_fast = 0, resetn, valid_in, CLOAD;
  logic [15:0] din;
  logic [10:0] CADDR;
  logic [18:0] CIN;
  logic ready_a, ready_b, ready_c, vo_a, vo_b, vo_c;
  logic [37:0] dout_a;
  logic [15:0] dout_b, dout_c;
  int vectors = 0, miscompares = 0;
  int h[64];
  int hist[$];
  always #5 clk_fast = ~clk_fast;
  da_fir_core #(.SHIFT(0), .OUT_W(38), .SAT_EN(0)) u_a (.clk_fast(clk_fast), .resetn(resetn), .din(din),
    .valid_in(valid_in), .ready_in(ready_a), .CLOAD(CLOAD), .CADDR(CADDR), .CIN(CIN), .dout(dout_a), .valid_out(vo_a));
  da_fir_core u_b (.clk_fast(clk_fast), .resetn(resetn), .din(din), .valid_in(valid_in), .ready_in(ready_b),
    .CLOAD(CLOAD), .CADDR(CADDR), .CIN(CIN), .dout(dout_b), .valid_out(vo_b));
  da_fir_core #(.SAT_EN(0)) u_c (.clk_fast(clk_fast), .resetn(resetn), .din(din), .valid_in(valid_in),
    .ready_in(ready_c), .CLOAD(CLOAD), .CADDR(CADDR), .CIN(CIN), .dout(dout_c), .valid_out(vo_c));
  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint model_y();
    longint s = 0;
    foreach (hist[k]) s += longint'(h[k]) * longint'(hist[k]);
    return s;
  endfunction
  function automatic longint exp_out(input longint y, input int sh, input int ow, input bit sat);
    longint r, mx, mn;
    r = sh > 0 ? (y + (64'sd1 <<< (sh - 1))) >>> sh : y;
    mx = (64'sd1 <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (sat) return r > mx ? mx : r < mn ? mn : r;
    return (r <<< (64 - ow)) >>> (64 - ow);
  endfunction
  task automatic load_lut();
    for (int t = 0; t < 8; t++)
      for (int a = 0; a < 256; a++) begin
        int e = 0;
        for (int i = 0; i < 8; i++) if (a[i]) e += h[t*8+i];
        @(negedge clk_fast);
        CLOAD = 1;
        CADDR = 11'(t * 256 + a);
        CIN = 19'(e);
      end
    @(negedge clk_fast);
    CLOAD = 0;
  endtask
  task automatic do_reset();
    @(negedge clk_fast);
    resetn = 0;
    repeat (2) @(negedge clk_fast);
    resetn = 1;
    hist.delete();
  endtask
  task automatic send(input int x);
    int n = 0;
    longint y;
    @(negedge clk_fast);
    valid_in = 1;
    din = 16'(x);
    #1 chk("ready", ready_a, 1);
    @(posedge clk_fast);
    #1 valid_in = 0;
    hist.push_front(x);
    if (hist.size() > 64) void'(hist.pop_back());
    y = model_y();
    while (!vo_a && n < 40) begin
      @(posedge clk_fast);
      #1 n++;
    end
    chk("latency", n, 18);
    chk("vo_bc", {vo_b, vo_c}, 2'b11);
    chk("dout_a", $signed(dout_a), exp_out(y, 0, 38, 0));
    chk("dout_b", $signed(dout_b), exp_out(y, 21, 16, 1));
    chk("dout_c", $signed(dout_c), exp_out(y, 21, 16, 0));
  endtask
  task automatic count_vo(input string tag, input int cycles);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk_fast);
      if (vo_a || vo_b || vo_c) cnt++;
    end
    chk(tag, cnt, 0);
  endtask
  initial begin
    int acc_t[$];
    int lows = 0;
    CLOAD = 0; valid_in = 0; din = 0; CADDR = 0; CIN = 0; resetn = 0;
    do_reset();
    #1;
    chk("rst_dout_a", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_vo", vo_a, 0);
    chk("rst_ready", ready_a, 1);
    count_vo("rst_idle_vo", 5);
    foreach (h[k]) h[k] = k + 1;
    load_lut();
    send(1);
    repeat (63) send(0);
    foreach (h[k]) h[k] = 1;
    load_lut();
    do_reset();
    send(-32768);
    send(32767);
    foreach (h[k]) h[k] = -32768;
    load_lut();
    do_reset();
    repeat (64) send(-32768);
    chk("sat_b", $signed(dout_b), 32767);
    chk("wrap_c", $signed(dout_c), -32768);
    foreach (h[k]) h[k] = int'($signed(16'($urandom)));
    load_lut();
    do_reset();
    repeat (40) send(int'($signed(16'($urandom))));
    @(negedge clk_fast);
    valid_in = 1;
    din = 16'(100);
    for (int c = 0; c < 72; c++) begin
      #1;
      if (!ready_a) lows++;
      else acc_t.push_back(c);
      @(negedge clk_fast);
    end
    valid_in = 0;
    chk("bp_accepts", acc_t.size(), 4);
    for (int i = 1; i < acc_t.size(); i++) chk("bp_gap", acc_t[i] - acc_t[i-1], 18);
    chk("bp_low", lows, 68);
    repeat (25) @(negedge clk_fast);
    do_reset();
    @(negedge clk_fast);
    CLOAD = 1; CADDR = 0; CIN = 0; valid_in = 1; din = 16'(5);
    #1 chk("cload_ready", ready_a, 0);
    repeat (3) @(negedge clk_fast);
    CLOAD = 0;
    valid_in = 0;
    count_vo("cload_noacc", 25);
    @(negedge clk_fast);
    valid_in = 1;
    din = 16'($urandom);
    @(posedge clk_fast);
    #1 valid_in = 0;
    repeat (5) @(posedge clk_fast);
    #1 resetn = 0;
    @(posedge clk_fast);
    #1 resetn = 1;
    hist.delete();
    chk("midrst_dout", dout_b, 0);
    chk("midrst_ready", ready_a, 1);
    count_vo("midrst_novo", 25);
    send(1);
    send(0);
    send(0);
    chk("midrst_h2", $signed(dout_a), h[2]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/da_fir_core.md
DA_FIR_CORE -- requirements
Module: da_fir_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, input sample width (signed).
REQ-002 SHALL have parameter TAPS, default 64, filter length; multiple of LUT_K.
REQ-003 SHALL have parameter LUT_K, default 8, taps per DA lookup table; NLUT = TAPS/LUT_K tables of 2^LUT_K entries.
REQ-004 SHALL have parameter COEF_W, default 16; LUT entry width LW = COEF_W+clog2(LUT_K) (19 at defaults).
REQ-005 SHALL have parameter OUT_W, default 16, output width (signed).
REQ-006 SHALL have parameter SHIFT, default 21, arithmetic right shift applied to the accumulator before output.
REQ-007 SHALL have parameter SAT_EN, default 1; 1 = saturate output, 0 = wrap (truncate).
REQ-008 clk_fast  input  1  single clock; all logic on rising edge.
REQ-009 resetn  input  1  reset, synchronous, active-low.
REQ-010 din  input  DATA_W  signed input sample.
REQ-011 valid_in  input  1  din valid; sample accepted when valid_in && ready_in.
REQ-012 ready_in  output  1  core can accept a sample this cycle.
REQ-013 CLOAD  input  1  LUT write enable.
REQ-014 CADDR  input  clog2(NLUT)+LUT_K  LUT write address {table index, entry index} (11 bits at defaults).
REQ-015 CIN  input  LW  signed LUT entry data.
REQ-016 dout  output  OUT_W  signed filter output, registered.
REQ-017 valid_out  output  1  one-cycle pulse, dout valid.

Function
REQ-018 SHALL implement y[n] = sum h[k]*x[n-k], k=0..TAPS-1, via bit-serial distributed arithmetic; LUT entry t,a SHALL hold sum of h[t*LUT_K+i] for each set bit i of a (software-precomputed).
REQ-019 SHALL hold a TAPS-deep DATA_W delay line; on accept, din enters tap 0 and every tap shifts by one.
REQ-020 FSM states IDLE, COMPUTE, OUTPUT; IDLE->COMPUTE on accept; COMPUTE lasts exactly DATA_W cycles (bit index b = 0..DATA_W-1, LSB first); COMPUTE->OUTPUT; OUTPUT->IDLE after one cycle.
REQ-021 In COMPUTE, table t address bit i SHALL be bit b of tap t*LUT_K+i; the NLUT outputs SHALL be summed signed to COEF_W+clog2(TAPS) bits.
REQ-022 Accumulator ACC_W = COEF_W+clog2(TAPS)+DATA_W bits, cleared on accept; acc += sum<<b for b<DATA_W-1; acc -= sum<<(DATA_W-1) at b = DATA_W-1 (two's-complement sign bit).
REQ-023 Output: r = (acc + 2^(SHIFT-1)) >>> SHIFT (no rounding term when SHIFT=0); SAT_EN=1 clamps r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; SAT_EN=0 takes low OUT_W bits.
REQ-024 dout SHALL be registered in OUTPUT and held until the next OUTPUT; valid_out high for exactly that one cycle.
REQ-025 Latency: valid_out SHALL assert exactly DATA_W+2 cycles after the accepting edge (18 at defaults); max throughput one sample per DATA_W+2 cycles.
REQ-026 ready_in = (state==IDLE) && !CLOAD; valid_in while ready_in low SHALL be ignored (sample dropped, no state change).
REQ-027 LUT write SHALL occur when CLOAD && state==IDLE; CLOAD in COMPUTE/OUTPUT SHALL be ignored.
REQ-028 Accumulator and LUT-sum arithmetic SHALL be exact (no internal overflow) for any coefficients and samples.

Reset
REQ-029 resetn low at a clock edge SHALL force state IDLE, clear all delay-line taps and accumulator, dout=0, valid_out=0; ready_in=1 once resetn high (CLOAD low).
REQ-030 Reset mid-COMPUTE SHALL abort the sample: no valid_out for it.
REQ-031 LUT contents SHALL NOT be reset; they persist across resetn.

Verification
REQ-032 Reset: resetn=0 for 2 cycles, then 1 -> dout=0, valid_out=0, ready_in=1, no valid_out until a sample is accepted.
REQ-033 Impulse (SHIFT=0, OUT_W=38, SAT_EN=0, h[k]=k+1): din=1 then 63 zeros -> dout sequence 1,2,...,64, each valid_out exactly 18 cycles after its accept.
REQ-034 Sign bit: all h[k]=1, zeroed delay line, din=-32768 once (SHIFT=0, OUT_W=38) -> dout=-32768; next din=32767 -> dout=-1.
REQ-035 Saturation (defaults): all h=-32768, 64 samples din=-32768 -> final dout=32767 (unsaturated 32768); same with SAT_EN=0 -> -32768.
REQ-036 Backpressure: valid_in held high, CLOAD=0 -> accepts spaced exactly 18 cycles, ready_in low 17 of every 18 cycles; CLOAD=1 in IDLE -> ready_in=0, no accept.
REQ-037 Reset mid-op: resetn low during COMPUTE bit 5 -> no valid_out; following impulse yields clean h[k] response with previously loaded LUT intact.
